// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the ALU (0),
// MUL (1) and MEM (2) completion pipelines. The oldest valid completion,
// measured as ROB distance from the head, is registered into a one-entry
// writeback buffer. A downstream stall can hold that buffer.
module wb_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int ROB_W  = 3
) (
  input  logic                clk,
  input  logic                reset,      // synchronous, active-low
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*DATA_W-1:0] req_data,
  input  logic [3*REG_W-1:0]  req_dest,
  input  logic [2:0]          req_we,
  input  logic [3*ROB_W-1:0]  req_rob,
  input  logic [3*DATA_W-1:0] req_pc,
  input  logic [5:0]          req_ex,
  input  logic [ROB_W-1:0]    rob_head,
  input  logic                flush,
  input  logic                wb_stall,
  output logic                wb_valid,
  output logic [DATA_W-1:0]   wb_result,
  output logic [REG_W-1:0]    wb_dest,
  output logic                wb_we,
  output logic [ROB_W-1:0]    wb_rob,
  output logic [DATA_W-1:0]   wb_pc,
  output logic [1:0]          wb_ex,
  output logic                wb_enable,
  output logic [1:0]          grant_id
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    STALLED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [REG_W-1:0]    dest_q,  dest_d;
  logic                we_q,    we_d;
  logic [ROB_W-1:0]    rob_q,   rob_d;
  logic [DATA_W-1:0]   pc_q,    pc_d;
  logic [1:0]          ex_q,    ex_d;
  logic [1:0]          gid_q,   gid_d;

  logic [ROB_W-1:0]    age [3];
  logic                win_valid;
  logic [1:0]          win_idx;
  logic [ROB_W-1:0]    best_age;
  logic                accept;
  logic                transfer;

  // Age of each requester: ROB distance from the head, wrapping modulo the ROB size.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      age[i] = req_rob[i*ROB_W +: ROB_W] - rob_head;
    end
  end

  // Oldest valid requester wins; the strict compare leaves ties with the lower index.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_valid = 1'b0;
    win_idx   = 2'd0;
    best_age  = '0;
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && (!win_valid || age[i] < best_age)) begin
        win_valid = 1'b1;
        win_idx   = 2'(i);
        best_age  = age[i];
      end
    end
  end

  // Handshake: the buffer can take a new entry when empty or draining, never during a flush or reset.
  always_comb begin
    accept    = !flush && (state_q == EMPTY || !wb_stall);
    transfer  = reset && accept && win_valid;
    req_ready = transfer ? (3'b001 << win_idx) : 3'b000;
  end

  // Next-state and buffer contents: load on transfer, hold on stall, drain otherwise.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    we_d    = we_q;
    rob_d   = rob_q;
    pc_d    = pc_q;
    ex_d    = ex_q;
    gid_d   = gid_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (state_q != EMPTY && wb_stall) begin
      state_d = STALLED;
    end else if (transfer) begin
      state_d = FULL;
      data_d  = req_data[win_idx*DATA_W +: DATA_W];
      dest_d  = req_dest[win_idx*REG_W +: REG_W];
      we_d    = req_we[win_idx];
      rob_d   = req_rob[win_idx*ROB_W +: ROB_W];
      pc_d    = req_pc[win_idx*DATA_W +: DATA_W];
      ex_d    = req_ex[win_idx*2 +: 2];
      gid_d   = win_idx;
    end else begin
      state_d = EMPTY;
    end
  end

  // State and buffer registers; reset clears everything and drops any held entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      dest_q  <= '0;
      we_q    <= 1'b0;
      rob_q   <= '0;
      pc_q    <= '0;
      ex_q    <= '0;
      gid_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      rob_q   <= rob_d;
      pc_q    <= pc_d;
      ex_q    <= ex_d;
      gid_q   <= gid_d;
    end
  end

  // Outputs to the WB stage register; write enable and grant are qualified by validity.
  always_comb begin
    wb_valid  = (state_q != EMPTY);
    wb_result = data_q;
    wb_dest   = dest_q;
    wb_we     = we_q && wb_valid;
    wb_rob    = rob_q;
    wb_pc     = pc_q;
    wb_ex     = ex_q;
    wb_enable = !wb_stall;
    grant_id  = wb_valid ? gid_q : 2'd3;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the one-entry writeback buffer.
module tb_wb_port_arbiter;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int BW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*DW-1:0] req_data;
  logic [3*RW-1:0] req_dest;
  logic [2:0]      req_we;
  logic [3*BW-1:0] req_rob;
  logic [3*DW-1:0] req_pc;
  logic [5:0]      req_ex;
  logic [BW-1:0]   rob_head;
  logic            flush;
  logic            wb_stall;
  logic            wb_valid;
  logic [DW-1:0]   wb_result;
  logic [RW-1:0]   wb_dest;
  logic            wb_we;
  logic [BW-1:0]   wb_rob;
  logic [DW-1:0]   wb_pc;
  logic [1:0]      wb_ex;
  logic            wb_enable;
  logic [1:0]      grant_id;

  int n_vec = 0;
  int n_err = 0;

  // Model of the output buffer.
  bit            m_held;
  logic [DW-1:0] m_data;
  logic [RW-1:0] m_dest;
  logic          m_we;
  logic [BW-1:0] m_rob;
  logic [DW-1:0] m_pc;
  logic [1:0]    m_ex;
  logic [1:0]    m_gid;

  wb_port_arbiter #(.DATA_W(DW), .REG_W(RW), .ROB_W(BW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_dest(req_dest), .req_we(req_we), .req_rob(req_rob), .req_pc(req_pc),
    .req_ex(req_ex), .rob_head(rob_head), .flush(flush), .wb_stall(wb_stall),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_dest(wb_dest), .wb_we(wb_we),
    .wb_rob(wb_rob), .wb_pc(wb_pc), .wb_ex(wb_ex), .wb_enable(wb_enable),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Oldest valid requester by plain modular distance; -1 if none is valid.
  function automatic int model_winner();
    int best = -1;
    int best_age = 1000;
    for (int i = 0; i < 3; i++) begin
      int a;
      a = (int'(req_rob[i*BW +: BW]) - int'(rob_head) + 8) % 8;
      if (req_valid[i] && a < best_age) begin
        best = i;
        best_age = a;
      end
    end
    return best;
  endfunction

  function automatic logic [2:0] model_ready();
    int w;
    w = model_winner();
    if (!reset || flush || (m_held && wb_stall) || w < 0) return 3'b000;
    return 3'(1 << w);
  endfunction

  task automatic model_tick();
    int w;
    w = model_winner();
    if (!reset) begin
      m_held = 0; m_data = '0; m_dest = '0; m_we = 0;
      m_rob = '0; m_pc = '0; m_ex = '0; m_gid = 2'd3;
    end else if (flush) begin
      m_held = 0;
    end else if (!m_held || !wb_stall) begin
      if (w >= 0) begin
        m_held = 1;
        m_data = req_data[w*DW +: DW];
        m_dest = req_dest[w*RW +: RW];
        m_we   = req_we[w];
        m_rob  = req_rob[w*BW +: BW];
        m_pc   = req_pc[w*DW +: DW];
        m_ex   = req_ex[w*2 +: 2];
        m_gid  = 2'(w);
      end else begin
        m_held = 0;
      end
    end
  endtask

  // Advance one clock edge, keep the model in step, then leave the edge behind.
  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d,
                         input logic [RW-1:0] dst, input logic w,
                         input logic [BW-1:0] tag, input logic [DW-1:0] p,
                         input logic [1:0] e);
    req_valid[i]         = v;
    req_data[i*DW +: DW] = d;
    req_dest[i*RW +: RW] = dst;
    req_we[i]            = w;
    req_rob[i*BW +: BW]  = tag;
    req_pc[i*DW +: DW]   = p;
    req_ex[i*2 +: 2]     = e;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(0, 1, 16'h1111, 3'd1, 1, 3'd0, 16'h0100, 2'd1);
    set_req(1, 1, 16'h2222, 3'd2, 1, 3'd1, 16'h0200, 2'd2);
    set_req(2, 1, 16'h3333, 3'd3, 1, 3'd2, 16'h0300, 2'd3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_ready !== 3'b000) begin
        n_err++;
        $display("FAIL reset_ready cycle %0d: got %b, expected 000", c, req_ready);
      end
      tick();
    end
    reset = 1'b1;
    req_valid = 3'b000;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, wb_we, grant_id} !== {1'b0, 1'b0, 2'd3}) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b we=%b gid=%0d, expected 0 0 3", wb_valid, wb_we, grant_id);
    end
    n_vec++;
    if ({wb_result, wb_dest, wb_rob, wb_pc, wb_ex} !== '0) begin
      n_err++;
      $display("FAIL reset_payload: got %h/%h/%h/%h/%h, expected all 0", wb_result, wb_dest, wb_rob, wb_pc, wb_ex);
    end
    tick();
  endtask

  task automatic test_age_wrap();
    logic [2:0] exp_ready [3] = '{3'b100, 3'b010, 3'b001};
    logic [1:0] exp_gid   [3] = '{2'd2, 2'd1, 2'd0};
    logic [DW-1:0] exp_d  [3] = '{16'hC0C0, 16'hB0B0, 16'hA0A0};
    rob_head = 3'd6;
    set_req(0, 1, 16'hA0A0, 3'd1, 1, 3'd1, 16'h1000, 2'd0);
    set_req(1, 1, 16'hB0B0, 3'd2, 1, 3'd7, 16'h2000, 2'd0);
    set_req(2, 1, 16'hC0C0, 3'd3, 1, 3'd6, 16'h3000, 2'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (req_ready !== exp_ready[k]) begin
        n_err++;
        $display("FAIL age_ready step %0d: got %b, expected %b", k, req_ready, exp_ready[k]);
      end
      tick();
      req_valid[exp_gid[k]] = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({wb_valid, grant_id, wb_result} !== {1'b1, exp_gid[k], exp_d[k]}) begin
        n_err++;
        $display("FAIL age_grant step %0d: got v=%b gid=%0d d=%h, expected 1 %0d %h",
                 k, wb_valid, grant_id, wb_result, exp_gid[k], exp_d[k]);
      end
    end
    tick();
    @(negedge clk);
    n_vec++;
    if ({wb_valid, grant_id} !== {1'b0, 2'd3}) begin
      n_err++;
      $display("FAIL age_drain: got v=%b gid=%0d, expected 0 3", wb_valid, grant_id);
    end
  endtask

  task automatic test_stall_hold();
    rob_head = 3'd0;
    set_req(1, 1, 16'h1234, 3'd5, 1, 3'd1, 16'h4000, 2'd0);
    set_req(0, 1, 16'hAAAA, 3'd2, 1, 3'd4, 16'h5000, 2'd0);
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL stall_first_ready: got %b, expected 010", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({req_ready, wb_valid, wb_result, wb_dest, wb_enable} !== {3'b000, 1'b1, 16'h1234, 3'd5, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: got rdy=%b v=%b d=%h dst=%0d en=%b, expected 000 1 1234 5 0",
                 c, req_ready, wb_valid, wb_result, wb_dest, wb_enable);
      end
      tick();
    end
    wb_stall = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({req_ready, wb_result, wb_enable} !== {3'b001, 16'h1234, 1'b1}) begin
      n_err++;
      $display("FAIL stall_release: got rdy=%b d=%h en=%b, expected 001 1234 1", req_ready, wb_result, wb_enable);
    end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({grant_id, wb_result, wb_dest} !== {2'd0, 16'hAAAA, 3'd2}) begin
      n_err++;
      $display("FAIL stall_next: got gid=%0d d=%h dst=%0d, expected 0 aaaa 2", grant_id, wb_result, wb_dest);
    end
    tick();
  endtask

  task automatic test_tie_break();
    rob_head = 3'd0;
    set_req(0, 1, 16'h0A0A, 3'd1, 1, 3'd2, 16'h6000, 2'd0);
    set_req(2, 1, 16'h0C0C, 3'd3, 0, 3'd2, 16'h7000, 2'd2);
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL tie_ready: got %b, expected 001", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({grant_id, req_ready} !== {2'd0, 3'b100}) begin
      n_err++;
      $display("FAIL tie_first: got gid=%0d rdy=%b, expected 0 100", grant_id, req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, grant_id, wb_we, wb_ex} !== {1'b1, 2'd2, 1'b0, 2'd2}) begin
      n_err++;
      $display("FAIL tie_second: got v=%b gid=%0d we=%b ex=%0d, expected 1 2 0 2", wb_valid, grant_id, wb_we, wb_ex);
    end
    tick();
  endtask

  task automatic test_flush_stalled();
    set_req(0, 1, 16'h5555, 3'd4, 1, 3'd3, 16'h8000, 2'd0);
    tick();
    req_valid[0] = 1'b0;
    wb_stall = 1'b1;
    tick();
    set_req(1, 1, 16'h6666, 3'd6, 1, 3'd5, 16'h9000, 2'd1);
    flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req_ready, wb_valid} !== {3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL flush_cycle: got rdy=%b v=%b, expected 000 1", req_ready, wb_valid);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, wb_we, grant_id, req_ready} !== {1'b0, 1'b0, 2'd3, 3'b010}) begin
      n_err++;
      $display("FAIL flush_after: got v=%b we=%b gid=%0d rdy=%b, expected 0 0 3 010",
               wb_valid, wb_we, grant_id, req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({wb_valid, grant_id, wb_result} !== {1'b1, 2'd1, 16'h6666}) begin
      n_err++;
      $display("FAIL flush_mul: got v=%b gid=%0d d=%h, expected 1 1 6666", wb_valid, grant_id, wb_result);
    end
    wb_stall = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    set_req(0, 1, 16'h7777, 3'd7, 1, 3'd0, 16'hA000, 2'd0);
    tick();
    @(negedge clk);
    n_vec++;
    if ({wb_valid, wb_we} !== 2'b11) begin
      n_err++;
      $display("FAIL midrst_loaded: got v=%b we=%b, expected 1 1", wb_valid, wb_we);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b000) begin
      n_err++;
      $display("FAIL midrst_ready: got %b, expected 000", req_ready);
    end
    tick();
    reset = 1'b1;
    req_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({wb_valid, wb_we, grant_id} !== {1'b0, 1'b0, 2'd3}) begin
        n_err++;
        $display("FAIL midrst_after cycle %0d: got v=%b we=%b gid=%0d, expected 0 0 3", c, wb_valid, wb_we, grant_id);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      wb_stall  = ($urandom_range(0, 2) == 0);
      rob_head  = 3'($urandom);
      req_valid = 3'($urandom);
      req_data  = 48'({$urandom, $urandom});
      req_dest  = 9'($urandom);
      req_we    = 3'($urandom);
      req_rob   = 9'($urandom);
      req_pc    = 48'({$urandom, $urandom});
      req_ex    = 6'($urandom);
      @(negedge clk);
      n_vec++;
      if (req_ready !== model_ready()) begin
        n_err++;
        $display("FAIL rand_ready cycle %0d: got %b, expected %b", c, req_ready, model_ready());
      end
      n_vec++;
      if ({wb_valid, wb_we, grant_id, wb_enable} !==
          {m_held, m_held && m_we, m_held ? m_gid : 2'd3, !wb_stall}) begin
        n_err++;
        $display("FAIL rand_ctrl cycle %0d: got v=%b we=%b gid=%0d en=%b, expected %b %b %0d %b",
                 c, wb_valid, wb_we, grant_id, wb_enable, m_held, m_held && m_we,
                 m_held ? m_gid : 2'd3, !wb_stall);
      end
      if (m_held) begin
        n_vec++;
        if ({wb_result, wb_dest, wb_rob, wb_pc, wb_ex} !== {m_data, m_dest, m_rob, m_pc, m_ex}) begin
          n_err++;
          $display("FAIL rand_payload cycle %0d: got %h/%h/%h/%h/%h, expected %h/%h/%h/%h/%h",
                   c, wb_result, wb_dest, wb_rob, wb_pc, wb_ex, m_data, m_dest, m_rob, m_pc, m_ex);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0; req_data = '0; req_dest = '0; req_we = '0;
    req_rob   = '0; req_pc = '0;   req_ex = '0;
    rob_head  = '0; flush = 1'b0;  wb_stall = 1'b0;
    m_held = 0; m_data = '0; m_dest = '0; m_we = 0;
    m_rob = '0; m_pc = '0; m_ex = '0; m_gid = 2'd3;
    test_reset();
    test_age_wrap();
    test_stall_hold();
    test_tie_break();
    test_flush_stalled();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
